vpu_deload_seq: RTL and testbench

- Parametrised deload sequencer for the tiled vector unit. Successor to the fixed ROW_A x ROW_A deload counter.
- Walks a runtime-sized result tile (cfg_rows x cfg_cols) after a compute pass and emits one (row, col, linear address) beat per cycle to the result writeback path.
- Uses a valid/ready handshake, start/done control and configuration error reporting.
- Sits between the PE array controller (start) and the result buffer / writeback port (out_*).

---
 rtl/vpu_deload_pkg.sv | 40 ++++
 rtl/vpu_wrap_cnt.sv | 45 ++++
 rtl/vpu_deload_seq.sv | 161 ++++++++++++++++
 tb/tb_vpu_deload_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vpu_deload_pkg.sv
// ---------------------------------------------------------------------------
// vpu_deload_pkg: shared state type, width helpers and config check for the deload sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ROW_A
`define ROW_A 4
`endif

package vpu_deload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width able to hold the values 0..max.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

  // Width of an index ranging 0..max-1, never narrower than one bit.
  function automatic int idx_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

  function automatic int addr_w(input int rmax, input int cmax);
    return (rmax * cmax > 1) ? $clog2(rmax * cmax) : 1;
  endfunction

  function automatic logic cfg_legal(input int rows, input int cols,
                                     input int rmax, input int cmax);
    return (rows >= 1) && (rows <= rmax) && (cols >= 1) && (cols <= cmax);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vpu_wrap_cnt.sv
// ---------------------------------------------------------------------------
// vpu_wrap_cnt: index counter with enable, clear and runtime wrap limit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpu_wrap_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // wrap_o flags that the next enabled step returns to zero.
  assign wrap_o = (cnt_q == limit_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vpu_deload_seq.sv
// ---------------------------------------------------------------------------
// vpu_deload_seq: runtime-sized result tile walker; VPU_DELOAD_TRANSPOSE_EN adds column-major walk
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vpu_deload_seq
  import vpu_deload_pkg::*;
#(
  parameter int ROW_MAX = `ROW_A,
  parameter int COL_MAX = `ROW_A,
  parameter int RW      = cnt_w(ROW_MAX),
  parameter int CW      = cnt_w(COL_MAX),
  parameter int AW      = addr_w(ROW_MAX, COL_MAX)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [RW-1:0]             cfg_rows,
  input  logic [CW-1:0]             cfg_cols,
`ifdef VPU_DELOAD_TRANSPOSE_EN
  input  logic                      cfg_transpose,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [idx_w(ROW_MAX)-1:0] count_deload_a,
  output logic [idx_w(COL_MAX)-1:0] count_deload_w,
  output logic [AW-1:0]             out_addr,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int AIW = idx_w(ROW_MAX);
  localparam int WIW = idx_w(COL_MAX);

  state_e          state_q, state_d;
  logic [RW-1:0]   rows_q, rows_d;
  logic [CW-1:0]   cols_q, cols_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            done_q, cfg_err_q;
  logic            w_tr;
  logic            w_start_idle, w_go, w_bad, w_beat, w_clr;
  logic            w_en_a, w_en_w, w_wrap_a, w_wrap_w;
  logic [AIW-1:0]  w_cnt_a;
  logic [WIW-1:0]  w_cnt_w;

  assign w_start_idle = start && (state_q == IDLE);
  assign w_go         = w_start_idle &&  cfg_legal(32'(cfg_rows), 32'(cfg_cols), ROW_MAX, COL_MAX);
  assign w_bad        = w_start_idle && !cfg_legal(32'(cfg_rows), 32'(cfg_cols), ROW_MAX, COL_MAX);
  assign w_beat       = out_valid && out_ready;
  assign w_clr        = w_go || (state_q == DONE);

`ifdef VPU_DELOAD_TRANSPOSE_EN
  logic tr_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_q <= 1'b0;
    end else if (w_go) begin
      tr_q <= cfg_transpose;
    end
  end
  assign w_tr = tr_q;
`else
  assign w_tr = 1'b0;
`endif

  // The inner index steps on every beat, the outer one only on an inner wrap.
  assign w_en_a = w_beat && ( w_tr || w_wrap_w);
  assign w_en_w = w_beat && (!w_tr || w_wrap_a);

  vpu_wrap_cnt #(.W(AIW)) u_cnt_a (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (w_clr),
    .en_i    (w_en_a),
    .limit_i (AIW'(rows_q - RW'(1))),
    .cnt_o   (w_cnt_a),
    .wrap_o  (w_wrap_a)
  );

  vpu_wrap_cnt #(.W(WIW)) u_cnt_w (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (w_clr),
    .en_i    (w_en_w),
    .limit_i (WIW'(cols_q - CW'(1))),
    .cnt_o   (w_cnt_w),
    .wrap_o  (w_wrap_w)
  );

  assign out_valid      = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign out_last       = out_valid && w_wrap_a && w_wrap_w;
  assign count_deload_a = w_cnt_a;
  assign count_deload_w = w_cnt_w;
  assign out_addr       = addr_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (w_go) begin
          state_d = RUN;
          rows_d  = cfg_rows;
          cols_d  = cfg_cols;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (w_beat) begin
          if (out_last) begin
            state_d = DONE;
          end
          // Column-major: step by a full row, and restart at the next column on inner wrap.
          if (!w_tr) begin
            addr_d = addr_q + AW'(1);
          end else if (w_wrap_a) begin
            addr_d = AW'(w_cnt_w) + AW'(1);
          end else begin
            addr_d = addr_q + AW'(cols_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      addr_q    <= addr_d;
      done_q    <= (state_q == DONE);
      cfg_err_q <= w_bad;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vpu_deload_seq.sv
// ---------------------------------------------------------------------------
// tb_vpu_deload_seq: directed self-checking bench for the deload sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vpu_deload_seq;

  localparam int RMAX = 4;
  localparam int CMAX = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] cfg_rows;
  logic [2:0] cfg_cols;
  logic       cfg_transpose;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count_deload_a;
  logic [1:0] count_deload_w;
  logic [3:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  vpu_deload_seq #(
    .ROW_MAX (RMAX),
    .COL_MAX (CMAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_rows       (cfg_rows),
    .cfg_cols       (cfg_cols),
`ifdef VPU_DELOAD_TRANSPOSE_EN
    .cfg_transpose  (cfg_transpose),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count_deload_a (count_deload_a),
    .count_deload_w (count_deload_w),
    .out_addr       (out_addr),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench at the negedge where the first beat must be presented.
  task automatic do_start(input int r, input int c, input logic tr);
    @(negedge clk);
    start = 1'b1; cfg_rows = 3'(r); cfg_cols = 3'(c); cfg_transpose = tr;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", {31'd0, out_valid}, 1);
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic walk(input int r, input int c, input int mode, input logic tr);
    int ea = 0, ew = 0, beats = 0, cyc = 0;
    logic rdy;
    while (beats < r * c) begin
      if (cyc >= 200) begin
        n_checks++; n_errors++;
        $display("FAIL walk_timeout got=%0d beats exp=%0d", beats, r * c);
        break;
      end
      rdy = (mode == 0) || (cyc % 3 == 0);
      out_ready = rdy;
      chk("valid", {31'd0, out_valid}, 1);
      chk("idx_a", {30'd0, count_deload_a}, 32'(ea));
      chk("idx_w", {30'd0, count_deload_w}, 32'(ew));
      chk("addr",  {28'd0, out_addr}, 32'(ea * c + ew));
      chk("last",  {31'd0, out_last}, {31'd0, (ea == r - 1) && (ew == c - 1)});
      @(negedge clk);
      if (rdy) begin
        beats++;
        if (!tr) begin
          if (ew == c - 1) begin ew = 0; ea++; end else ew++;
        end else begin
          if (ea == r - 1) begin ea = 0; ew++; end else ea++;
        end
      end
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  // Called at the negedge right after the final beat was accepted.
  task automatic finish_chk();
    chk("post_valid", {31'd0, out_valid}, 0);
    chk("done_busy",  {31'd0, busy}, 1);
    chk("done_early", {31'd0, done}, 0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 1);
    chk("idle_busy",  {31'd0, busy}, 0);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 0);
    chk("idle_valid", {31'd0, out_valid}, 0);
  endtask

  task automatic bad_start(input int r, input int c);
    @(negedge clk);
    start = 1'b1; cfg_rows = 3'(r); cfg_cols = 3'(c);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err",     {31'd0, cfg_err}, 1);
    chk("bad_busy",    {31'd0, busy}, 0);
    chk("bad_valid",   {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("cfg_err_end", {31'd0, cfg_err}, 0);
    chk("bad_valid2",  {31'd0, out_valid}, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
    cfg_transpose = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_err",   {31'd0, cfg_err}, 0);
    chk("rst_addr",  {28'd0, out_addr}, 0);
    chk("rst_last",  {31'd0, out_last}, 0);
    reset = 1'b1;

    // 3x4 tile, ready held high
    do_start(3, 4, 1'b0);
    walk(3, 4, 0, 1'b0);
    finish_chk();

    // 2x2 tile with stalls
    do_start(2, 2, 1'b0);
    walk(2, 2, 1, 1'b0);
    finish_chk();

    // Illegal configurations
    bad_start(0, 2);
    bad_start(2, CMAX + 1);
    bad_start(RMAX + 1, 1);

    // 1x1 tile with an ignored start during RUN
    do_start(1, 1, 1'b0);
    chk("one_last", {31'd0, out_last}, 1);
    chk("one_addr", {28'd0, out_addr}, 0);
    start = 1'b1; cfg_rows = 3'd2; cfg_cols = 3'd2;
    @(negedge clk);
    start = 1'b0;
    chk("run_start_valid", {31'd0, out_valid}, 1);
    chk("run_start_addr",  {28'd0, out_addr}, 0);
    chk("run_start_last",  {31'd0, out_last}, 1);
    chk("run_start_err",   {31'd0, cfg_err}, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    finish_chk();

    // Reset in the middle of a 4x4 pass, at beat 5
    do_start(4, 4, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    chk("mid_addr",  {28'd0, out_addr}, 4);
    chk("mid_valid", {31'd0, out_valid}, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 0);
    chk("async_busy",  {31'd0, busy}, 0);
    chk("async_addr",  {28'd0, out_addr}, 0);
    chk("async_idx_w", {30'd0, count_deload_w}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done", {31'd0, done}, 0);
    end
    do_start(2, 2, 1'b0);
    walk(2, 2, 0, 1'b0);
    finish_chk();

`ifdef VPU_DELOAD_TRANSPOSE_EN
    // Column-major 2x3: addresses 0,3,1,4,2,5
    do_start(2, 3, 1'b1);
    walk(2, 3, 0, 1'b1);
    finish_chk();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
